// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display path: digit count, the
// active-low segment code table and anode helpers.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_code_t;

  // Index is the hex value, entry is the active-low {g,f,e,d,c,b,a} pattern.
  localparam seg_code_t SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [7:0] BLANK_AN = 8'hFF;

  function automatic logic single_low(input logic [7:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = an[i] ? idx : 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational reverse lookup of an active-low segment pattern into its hex
// value; hit is low for patterns that are not in the code table.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] hex,
  output logic       hit
);

  // Table search: at most one entry can match since the codes are distinct.
  always_comb begin
    hex = 4'd0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hex = (segs == SEG_CODES[i]) ? 4'(i) : hex;
      hit = hit | (segs == SEG_CODES[i]);
    end
  end

endmodule

// File: rtl/sevenseg_monitor.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment display:
// waits for each dwell to settle, decodes it and rebuilds the digit registers.
module sevenseg_monitor
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] an_1,
  input  logic [6:0] segs_1,
  input  logic       clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [3:0] d7,
  output logic [7:0] dig_valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err,
  output logic       stalled
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [14:0]   samp_r;
  logic [SW-1:0] scnt_r;
  logic          armed_r;
  logic [7:0]    mask_r;
  logic [TW-1:0] tcnt_r;
  logic [3:0]    d_r [NUM_DIGITS];

  logic [3:0]    hex_s;
  logic          hit_s;
  logic [2:0]    idx_s;
  logic          changed_s;
  logic          settle_ev_s;
  logic          cap_s;
  logic          serr_s;
  logic          aerr_s;
  logic [7:0]    mask_base_s;
  logic [7:0]    mask_next_s;
  logic [TW-1:0] tcnt_next_s;

  sevenseg_decode u_decode (
    .segs (samp_r[6:0]),
    .hex  (hex_s),
    .hit  (hit_s)
  );

  // Settle detection and classification of the settled sample.
  always_comb begin
    changed_s   = ({an_1, segs_1} != samp_r);
    settle_ev_s = armed_r && (scnt_r == SETTLE_MAX);
    idx_s       = low_index(samp_r[14:7]);
    cap_s       = 1'b0;
    serr_s      = 1'b0;
    aerr_s      = 1'b0;
    if (settle_ev_s && !clr && (samp_r[14:7] != BLANK_AN)) begin
      if (single_low(samp_r[14:7])) begin
        cap_s  = hit_s;
        serr_s = !hit_s;
      end else begin
        aerr_s = 1'b1;
      end
    end else begin
      cap_s  = 1'b0;
    end
  end

  // Frame mask restarts after a completed frame; errors wipe it.
  always_comb begin
    mask_base_s = (mask_r == 8'hFF) ? 8'h00 : mask_r;
    mask_next_s = (serr_s || aerr_s) ? 8'h00 :
                  cap_s ? (mask_base_s | (8'h01 << idx_s)) : mask_base_s;
    tcnt_next_s = cap_s ? {TW{1'b0}} :
                  (tcnt_r == TIMEOUT_MAX) ? tcnt_r : (tcnt_r + TW'(1));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_r     <= {8'hFF, 7'h7F};
      scnt_r     <= {SW{1'b0}};
      armed_r    <= 1'b1;
      mask_r     <= 8'h00;
      tcnt_r     <= {TW{1'b0}};
      dig_valid  <= 8'h00;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
      stalled    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d_r[i] <= 4'd0;
      end
    end else begin
      samp_r     <= {an_1, segs_1};
      scnt_r     <= changed_s ? SW'(1) :
                    (scnt_r == SETTLE_MAX) ? scnt_r : (scnt_r + SW'(1));
      // Re-arm on any new pattern (or clr) so each dwell yields one event.
      armed_r    <= changed_s || clr || (armed_r && !settle_ev_s);
      seg_err    <= serr_s;
      an_err     <= aerr_s;
      frame_done <= (mask_r == 8'hFF) && !clr;
      if (clr) begin
        mask_r    <= 8'h00;
        tcnt_r    <= {TW{1'b0}};
        dig_valid <= 8'h00;
        stalled   <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          d_r[i] <= 4'd0;
        end
      end else begin
        mask_r  <= mask_next_s;
        tcnt_r  <= tcnt_next_s;
        stalled <= (tcnt_next_s == TIMEOUT_MAX);
        if (cap_s) begin
          d_r[idx_s]       <= hex_s;
          dig_valid[idx_s] <= 1'b1;
        end else if (serr_s) begin
          dig_valid[idx_s] <= 1'b0;
        end else begin
          dig_valid <= dig_valid;
        end
      end
    end
  end

  assign d0 = d_r[0];
  assign d1 = d_r[1];
  assign d2 = d_r[2];
  assign d3 = d_r[3];
  assign d4 = d_r[4];
  assign d5 = d_r[5];
  assign d6 = d_r[6];
  assign d7 = d_r[7];

endmodule

// File: tb/tb_sevenseg_monitor.sv
// Bench for sevenseg_monitor: directed scans plus random dwells, every cycle
// compared against a pin-history reference model.
module tb_sevenseg_monitor;

  localparam int S = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] an_1;
  logic [6:0] segs_1;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] dig_valid;
  logic       frame_done, seg_err, an_err, stalled;

  always #5 clk = ~clk;

  sevenseg_monitor #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .an_1(an_1), .segs_1(segs_1), .clr(clr),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .dig_valid(dig_valid), .frame_done(frame_done), .seg_err(seg_err),
    .an_err(an_err), .stalled(stalled)
  );

  logic [6:0] codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int errs = 0;
  int checks = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int ae_cnt = 0;

  // Reference: last pin pattern, how long it has been held, whether its dwell
  // was already reported, plus the observable outputs.
  logic [14:0] m_pins;
  int          m_run;
  bit          m_done;
  int          m_d [8];
  logic [7:0]  m_valid, m_mask;
  int          m_t;
  bit          m_stall, m_fd, m_se, m_ae;

  function automatic int code_of(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (codes[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] an;
    logic [6:0] sg;
    logic [7:0] base;
    bit ev, cap;
    int h, idx, zeros;
    if (rst) begin
      m_pins = {8'hFF, 7'h7F}; m_run = 0; m_done = 1'b0;
      for (int k = 0; k < 8; k++) m_d[k] = 0;
      m_valid = 8'h00; m_mask = 8'h00; m_t = 0;
      m_stall = 1'b0; m_fd = 1'b0; m_se = 1'b0; m_ae = 1'b0;
      return;
    end
    an = m_pins[14:7];
    sg = m_pins[6:0];
    ev = (m_run >= S) && !m_done;
    m_fd = (m_mask == 8'hFF) && !clr;
    m_se = 1'b0; m_ae = 1'b0; cap = 1'b0; h = -1; idx = 0;
    if (ev && !clr && an != 8'hFF) begin
      zeros = 0;
      for (int b = 0; b < 8; b++) begin
        if (!an[b]) begin zeros++; idx = b; end
      end
      if (zeros > 1) m_ae = 1'b1;
      else begin
        h = code_of(sg);
        if (h >= 0) cap = 1'b1; else m_se = 1'b1;
      end
    end
    base = (m_mask == 8'hFF) ? 8'h00 : m_mask;
    if (clr) begin
      for (int k = 0; k < 8; k++) m_d[k] = 0;
      m_valid = 8'h00; m_mask = 8'h00; m_t = 0; m_stall = 1'b0;
    end else if (cap) begin
      m_d[idx] = h; m_valid[idx] = 1'b1; m_mask = base | (8'h01 << idx);
      m_t = 0; m_stall = 1'b0;
    end else begin
      if (m_se) m_valid[idx] = 1'b0;
      m_mask = (m_se || m_ae) ? 8'h00 : base;
      if (m_t < T) m_t++;
      m_stall = (m_t == T);
    end
    if ({an_1, segs_1} != m_pins) begin
      m_pins = {an_1, segs_1}; m_run = 1; m_done = 1'b0;
    end else begin
      if (m_run < S) m_run++;
      if (ev) m_done = 1'b1;
    end
    if (clr) m_done = 1'b0;
  endtask

  function automatic logic [31:0] model_d();
    logic [31:0] v;
    for (int k = 0; k < 8; k++) v[k*4 +: 4] = 4'(m_d[k]);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("digits", {d7, d6, d5, d4, d3, d2, d1, d0}, model_d());
    check("dig_valid", {24'd0, dig_valid}, {24'd0, m_valid});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    check("seg_err", {31'd0, seg_err}, {31'd0, m_se});
    check("an_err", {31'd0, an_err}, {31'd0, m_ae});
    check("stalled", {31'd0, stalled}, {31'd0, m_stall});
    fd_cnt += int'(frame_done);
    se_cnt += int'(seg_err);
    ae_cnt += int'(an_err);
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] an, input logic [6:0] sg, input int n);
    an_1 = an;
    segs_1 = sg;
    repeat (n) cyc();
  endtask

  initial begin
    logic [7:0]  an_v;
    logic [31:0] dsnap;
    int a, b, n;
    rst = 1'b1; clr = 1'b0;
    an_1 = 8'($urandom); segs_1 = 7'($urandom);
    @(negedge clk);
    repeat (3) begin
      an_1 = 8'($urandom); segs_1 = 7'($urandom);
      cyc();
    end
    check("rst_digits", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h0);
    rst = 1'b0;
    fd_cnt = 0; se_cnt = 0; ae_cnt = 0;
    hold(8'hFF, 7'h7F, 6);
    check("idle_events", 32'(fd_cnt + se_cnt + ae_cnt), 32'd0);

    // Two identical full scans, 8-cycle dwells.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) hold(~(8'h01 << k), codes[k], 8);
      check("frames_after_pass", 32'(fd_cnt), 32'(pass + 1));
    end
    check("scan_digits", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h76543210);
    check("scan_valid", {24'd0, dig_valid}, 32'h000000FF);

    // Short glitch is ignored; long dwell captures once.
    hold(8'hFE, 7'h40, 8);
    fd_cnt = 0; se_cnt = 0; ae_cnt = 0;
    hold(8'hFE, 7'h00, 3);
    hold(8'hFE, 7'h40, 8);
    check("glitch_d0", {28'd0, d0}, 32'd0);
    check("glitch_pulses", 32'(fd_cnt + se_cnt + ae_cnt), 32'd0);
    hold(8'hFE, 7'h00, 20);
    check("long_d0", {28'd0, d0}, 32'd8);

    // Bad segment code poisons the frame.
    fd_cnt = 0; se_cnt = 0;
    hold(8'hFE, 7'h7F, 8);
    check("bad_seg_err", 32'(se_cnt), 32'd1);
    check("bad_valid0", {31'd0, dig_valid[0]}, 32'd0);
    check("bad_d0_hold", {28'd0, d0}, 32'd8);
    for (int k = 1; k < 8; k++) hold(~(8'h01 << k), codes[k], 8);
    hold(8'hFF, 7'h7F, 4);
    check("bad_no_frame", 32'(fd_cnt), 32'd0);

    // Two anodes low: error, no digit change, mask wiped.
    ae_cnt = 0; fd_cnt = 0;
    dsnap = {d7, d6, d5, d4, d3, d2, d1, d0};
    hold(8'hFC, 7'h40, 8);
    check("an_err_cnt", 32'(ae_cnt), 32'd1);
    check("an_err_digits", {d7, d6, d5, d4, d3, d2, d1, d0}, dsnap);
    hold(8'hFE, 7'h40, 8);
    check("an_mask_cleared", 32'(fd_cnt), 32'd0);

    // Timeout after clr, recovery on capture.
    an_1 = 8'hFF; segs_1 = 7'h7F; clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (15) cyc();
    check("stall_at_15", {31'd0, stalled}, 32'd0);
    cyc();
    check("stall_at_16", {31'd0, stalled}, 32'd1);
    hold(8'hFE, 7'h40, 5);
    check("stall_recover", {31'd0, stalled}, 32'd0);

    // clr on the settle edge drops that capture.
    hold(8'hFB, 7'h24, 4);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_digits", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h0);
    check("clr_valid", {24'd0, dig_valid}, 32'd0);
    hold(8'hFB, 7'h24, 3);

    // Random dwells with occasional clr.
    for (int r = 0; r < 120; r++) begin
      a = $urandom_range(0, 7);
      n = $urandom_range(0, 9);
      if (n == 0) an_v = 8'hFF;
      else if (n == 1) begin
        b = (a + $urandom_range(1, 7)) % 8;
        an_v = ~((8'h01 << a) | (8'h01 << b));
      end else an_v = ~(8'h01 << a);
      an_1 = an_v;
      segs_1 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : codes[$urandom_range(0, 15)];
      n = $urandom_range(1, 10);
      repeat (n) begin
        clr = ($urandom_range(0, 29) == 0);
        cyc();
      end
      clr = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
